ysyx_24100006_ifu: RTL and testbench
====================================

# ysyx_24100006_ifu

Instruction fetch unit and the producing end of the IF→ID valid/ready link. Holds the architectural fetch PC, issues one word-aligned read at a time on a simple request/response instruction bus, and presents each fetched word with its PC+4 to the IF/ID pipeline register. Accepts redirects from the back end, such as a branch or trap flush. A redirect discards the in-flight fetch and restarts fetch at the new target.

## Interface
- RESET_PC, 32'h3000_0000, first fetch address after reset; bits [1:0] must be 0.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  redirect request; takes priority over every other event in the same cycle.
- redirect_pc_i  in  32  new fetch PC, sampled when flush_i=1; bits [1:0] forced to 0.
- req_valid  out  1  instruction-bus read request valid.
- req_ready  in  1  bus accepts the request this cycle.
- req_addr  out  32  read address; equals the current PC.
- rsp_valid  in  1  read data valid; the bus always accepts the response, so there is no rsp_ready.
- rsp_data  in  32  read data.
- rsp_err  in  1  bus error on this response.
- out_valid  out  1  fetched instruction valid toward IF/ID.
- out_ready  in  1  IF/ID can accept the instruction.
- instruction_o  out  32  fetched word.
- pc_add_4_o  out  32  PC of the fetched word plus 4.
- fault_o  out  1  fetched word came back with rsp_err; qualified by out_valid.
- pc_o  out  32  PC of the fetched word; present only with IFU_PC_TRACE_EN.

## Operation
- States:
  - IDLE: reset state only.
  - REQ: request pending on the bus.
  - WAIT: request accepted, response outstanding.
  - HOLD: fetched word buffered, waiting for out_ready.
  - DROP: response outstanding but stale, to be discarded.
- Exactly one request is outstanding at any time.
- Transitions without a flush:
  - IDLE→REQ unconditionally.
  - REQ→WAIT on req_valid&&req_ready.
  - WAIT→HOLD on rsp_valid. In the same edge, rsp_data, rsp_err, pc_q and pc_q+4 are latched into the output buffer.
  - HOLD→REQ on out_valid&&out_ready, with pc_q <= pc_q+4.
  - DROP→REQ on rsp_valid; the data is discarded.
- flush_i=1 always loads pc_q <= {redirect_pc_i[31:2],2'b00}. The state then changes as follows:
  - IDLE: moves to REQ.
  - REQ with req_ready=1 in the same cycle: moves to DROP, because that request is now in flight.
  - REQ with req_ready=0: stays in REQ; req_addr takes the new PC on the next cycle.
  - WAIT with rsp_valid=0: moves to DROP.
  - WAIT with rsp_valid=1: the response is discarded and the state moves to REQ.
  - HOLD: out_valid is cleared and the state moves to REQ. A simultaneous out_ready does not count as a transfer.
  - DROP: stays in DROP (still waiting for the stale response), or moves to REQ if rsp_valid=1 in the same cycle.
- Decoded outputs:
  - req_valid = (state==REQ); req_addr = pc_q.
  - out_valid = (state==HOLD). Buffer contents are stable while out_valid=1.
- Arithmetic: PC+4 is 32-bit, modulo 2^32. 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
- A bus fault is not a stall: the word is forwarded with fault_o=1, and the decode/trap logic handles it.

## Timing
- Reset values: state=IDLE, pc_q=RESET_PC, req_valid=0, out_valid=0, instruction_o=0, fault_o=0, pc_add_4_o=RESET_PC+4.
- Asserting reset_n low mid-transaction returns immediately to IDLE. Any response that arrives after reset is ignored (IDLE does not sample rsp_valid).
- First req_valid appears in the cycle after the first clock edge following reset release.
- Latency:
  - Response at edge N gives out_valid=1 from edge N onward (registered, no combinational path from rsp to out).
  - An out handshake at edge M gives req_valid=1 after M.
  - Best-case throughput with a zero-wait bus: one instruction per 3 cycles.
- Handshake rules:
  - req_addr holds while req_valid=1 && !req_ready, except across a flush.
  - out_* holds while out_valid=1 && !out_ready.
- No combinational path from out_ready or req_ready to any output.

## Configuration
- IFU_PC_TRACE_EN defined: pc_o is a port and a 32-bit pc buffer register exists, loaded alongside instruction_o (reset value RESET_PC).
- IFU_PC_TRACE_EN undefined: there is no pc_o port and no register; all other behaviour is identical.

## Structure
- The shared package ysyx_24100006_pkg holds:
  - the ifu_state_t enum (IDLE, REQ, WAIT, HOLD, DROP);
  - the default RESET_PC constant;
  - the INST_ALIGN_MASK constant, 32'hFFFF_FFFC.
- Single module: the FSM, PC register and output buffer are too tightly coupled for a useful sub-module.

## Test plan
- Reset release, zero-wait bus returning 32'h0000_0013 → req_addr=32'h3000_0000, then out_valid=1 with instruction_o=32'h0000_0013 and pc_add_4_o=32'h3000_0004; the next request goes to 32'h3000_0004.
- out_ready held 0 for 5 cycles in HOLD → outputs stable and no new req_valid; out_ready=1 → exactly one transfer, then req_addr=32'h3000_0004.
- flush_i with redirect_pc_i=32'h8000_0102 while in WAIT, stale response 2 cycles later → stale data never reaches out_valid; the next req_addr is 32'h8000_0100.
- flush_i in the same cycle as the REQ handshake → enters DROP, discards the response, then requests the redirect target; also check flush in HOLD with out_ready=1 → no transfer counted.
- rsp_err=1 with rsp_data=32'hDEAD_BEEF → out_valid=1, fault_o=1, instruction_o=32'hDEAD_BEEF; PC advances normally after the handshake.
- PC 32'hFFFF_FFFC fetched → pc_add_4_o=32'h0000_0000 and the next req_addr is 0; reset_n pulsed low while in WAIT → outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ysyx_24100006_pkg.sv
// Shared types and constants for the ysyx_24100006 fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_24100006_pkg;

  // Fetch FSM states; IDLE is only ever visited out of reset.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } ifu_state_t;

  localparam logic [31:0] RESET_PC        = 32'h3000_0000;
  localparam logic [31:0] INST_ALIGN_MASK = 32'hFFFF_FFFC;

  // Force a fetch address onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & INST_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/ysyx_24100006_ifu.sv
// Instruction fetch unit: one outstanding word read, result buffered toward IF/ID; optional pc_o via IFU_PC_TRACE_EN.
// Latency: response registered into the buffer (out_valid the edge it arrives); best case 3 cycles per instruction.
// Backpressure: buffer holds while out_ready=0 and no new request issues; flush discards in-flight or buffered work.
module ysyx_24100006_ifu
  import ysyx_24100006_pkg::*;
#(
  parameter logic [31:0] BOOT_PC = RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_add_4_o,
`ifdef IFU_PC_TRACE_EN
  output logic [31:0] pc_o,
`endif
  output logic        fault_o
);

  ifu_state_t  state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] pc4_q;
  logic        fault_q;
  logic [31:0] pc_next4;
`ifdef IFU_PC_TRACE_EN
  logic [31:0] pcbuf_q;
`endif

  // Sequential PC successor; wraps modulo 2^32.
  assign pc_next4 = pc_q + 32'd4;

  // Fetch FSM, PC register and output buffer; flush overrides every other event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= BOOT_PC;
      inst_q  <= 32'd0;
      fault_q <= 1'b0;
      pc4_q   <= BOOT_PC + 32'd4;
`ifdef IFU_PC_TRACE_EN
      pcbuf_q <= BOOT_PC;
`endif
    end else if (flush_i) begin
      pc_q <= align_pc(redirect_pc_i);
      case (state_q)
        // A request accepted in this very cycle is in flight and must be drained.
        REQ:     state_q <= req_ready ? DROP : REQ;
        WAIT:    state_q <= rsp_valid ? REQ : DROP;
        DROP:    state_q <= rsp_valid ? REQ : DROP;
        // IDLE and HOLD have nothing outstanding; HOLD drops its word.
        default: state_q <= REQ;
      endcase
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (req_ready) state_q <= WAIT;
        end
        WAIT: begin
          if (rsp_valid) begin
            state_q <= HOLD;
            inst_q  <= rsp_data;
            fault_q <= rsp_err;
            pc4_q   <= pc_next4;
`ifdef IFU_PC_TRACE_EN
            pcbuf_q <= pc_q;
`endif
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= REQ;
            pc_q    <= pc_next4;
          end
        end
        DROP: begin
          if (rsp_valid) state_q <= REQ;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // All outputs decode registered state only; no ready-to-output paths.
  assign req_valid     = (state_q == REQ);
  assign req_addr      = pc_q;
  assign out_valid     = (state_q == HOLD);
  assign instruction_o = inst_q;
  assign pc_add_4_o    = pc4_q;
  assign fault_o       = fault_q;
`ifdef IFU_PC_TRACE_EN
  assign pc_o          = pcbuf_q;
`endif

endmodule

// File: tb/tb_ysyx_24100006_ifu.sv
// Self-checking bench for ysyx_24100006_ifu with a scoreboard of expected IF/ID words.
// Latency: n/a.
// Backpressure: bench drives req_ready/out_ready directly.
module tb_ysyx_24100006_ifu;

  logic        clk;
  logic        reset_n;
  logic        flush_i;
  logic [31:0] redirect_pc_i;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction_o;
  logic [31:0] pc_add_4_o;
  logic        fault_o;
`ifdef IFU_PC_TRACE_EN
  logic [31:0] pc_o;
`endif

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  ysyx_24100006_ifu dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .instruction_o (instruction_o),
    .pc_add_4_o    (pc_add_4_o),
`ifdef IFU_PC_TRACE_EN
    .pc_o          (pc_o),
`endif
    .fault_o       (fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a bus request and check its address.
  task automatic wait_req(input string tag, input logic [31:0] addr);
    int n;
    n = 0;
    while (!req_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_valid"}, {31'd0, req_valid}, 32'd1);
    check({tag, "_req_addr"}, req_addr, addr);
  endtask

  // One bus transaction: request stalled req_lat cycles, response rsp_lat cycles after accept.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data,
                       input logic err, input int req_lat, input int rsp_lat);
    exp_t e;
    wait_req(tag, addr);
    repeat (req_lat) begin
      @(negedge clk);
      check({tag, "_req_hold_valid"}, {31'd0, req_valid}, 32'd1);
      check({tag, "_req_hold_addr"}, req_addr, addr);
    end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    repeat (rsp_lat) begin
      @(negedge clk);
      check({tag, "_wait_out_valid"}, {31'd0, out_valid}, 32'd0);
    end
    rsp_valid = 1'b1;
    rsp_data  = data;
    rsp_err   = err;
    e.inst = data; e.pc4 = addr + 32'd4; e.pc = addr; e.fault = err;
    exp_q.push_back(e);
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_data  = 32'd0;
    rsp_err   = 1'b0;
  endtask

  // Pop the next expected word and compare it against the IF/ID buffer.
  task automatic pop_cmp(input string tag, output exp_t e);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      e.inst = 32'd0; e.pc4 = 32'd0; e.pc = 32'd0; e.fault = 1'b0;
    end else begin
      e = exp_q.pop_front();
    end
    check({tag, "_inst"}, instruction_o, e.inst);
    check({tag, "_pc4"}, pc_add_4_o, e.pc4);
    check({tag, "_fault"}, {31'd0, fault_o}, {31'd0, e.fault});
`ifdef IFU_PC_TRACE_EN
    check({tag, "_pc"}, pc_o, e.pc);
`endif
  endtask

  // Consume the buffered word after hold cycles of backpressure.
  task automatic take_out(input string tag, input int hold);
    exp_t e;
    pop_cmp(tag, e);
    repeat (hold) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_inst"}, instruction_o, e.inst);
      check({tag, "_hold_pc4"}, pc_add_4_o, e.pc4);
      check({tag, "_hold_noreq"}, {31'd0, req_valid}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_xfer_done"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_next_req"}, {31'd0, req_valid}, 32'd1);
    check({tag, "_next_addr"}, req_addr, e.pc4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, {31'd0, req_valid}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_inst"}, instruction_o, 32'd0);
    check({tag, "_fault"}, {31'd0, fault_o}, 32'd0);
    check({tag, "_pc4"}, pc_add_4_o, 32'h3000_0004);
    check({tag, "_req_addr"}, req_addr, 32'h3000_0000);
  endtask

  initial begin
    exp_t e;
    n_checks = 0;
    n_fail = 0;
    reset_n = 1'b0;
    flush_i = 1'b0;
    redirect_pc_i = 32'd0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data = 32'd0;
    rsp_err = 1'b0;
    out_ready = 1'b0;

    // Reset state and first request timing.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    #1;
    check("rel_no_req", {31'd0, req_valid}, 32'd0);
    @(negedge clk);
    check("first_req", {31'd0, req_valid}, 32'd1);

    // Zero-wait fetch, then a stalled fetch with 5 cycles of out backpressure.
    fetch("f0", 32'h3000_0000, 32'h0000_0013, 1'b0, 0, 0);
    take_out("f0", 0);
    fetch("f1", 32'h3000_0004, 32'h1234_5678, 1'b0, 2, 1);
    take_out("f1", 5);

    // Flush while waiting for a response; the stale word arrives two cycles later.
    wait_req("flw", 32'h3000_0008);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    flush_i = 1'b1;
    redirect_pc_i = 32'h8000_0102;
    @(negedge clk);
    flush_i = 1'b0;
    check("flw_drop_noreq", {31'd0, req_valid}, 32'd0);
    @(negedge clk);
    check("flw_drop_noout", {31'd0, out_valid}, 32'd0);
    rsp_valid = 1'b1;
    rsp_data = 32'hBAD0_BAD0;
    @(negedge clk);
    rsp_valid = 1'b0;
    check("flw_stale_noout", {31'd0, out_valid}, 32'd0);

    // Flush coincident with the request handshake.
    wait_req("hsf", 32'h8000_0100);
    req_ready = 1'b1;
    flush_i = 1'b1;
    redirect_pc_i = 32'h0000_1000;
    @(negedge clk);
    req_ready = 1'b0;
    flush_i = 1'b0;
    check("hsf_drop_noreq", {31'd0, req_valid}, 32'd0);
    rsp_valid = 1'b1;
    rsp_data = 32'hBAD1_BAD1;
    @(negedge clk);
    rsp_valid = 1'b0;
    check("hsf_stale_noout", {31'd0, out_valid}, 32'd0);

    // Flush in HOLD alongside out_ready: no transfer, restart at redirect.
    fetch("hold", 32'h0000_1000, 32'h1111_0001, 1'b0, 0, 0);
    pop_cmp("hold", e);
    out_ready = 1'b1;
    flush_i = 1'b1;
    redirect_pc_i = 32'h0000_2000;
    @(negedge clk);
    out_ready = 1'b0;
    flush_i = 1'b0;
    check("hold_flush_noout", {31'd0, out_valid}, 32'd0);
    check("hold_flush_addr", req_addr, 32'h0000_2000);

    // Bus error forwarded as a fault, PC advances normally.
    fetch("err", 32'h0000_2000, 32'hDEAD_BEEF, 1'b1, 1, 2);
    take_out("err", 0);

    // Flush in REQ without req_ready retargets the pending request; then address wrap.
    flush_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    @(negedge clk);
    flush_i = 1'b0;
    check("reqf_valid", {31'd0, req_valid}, 32'd1);
    check("reqf_addr", req_addr, 32'hFFFF_FFFC);
    fetch("wrap", 32'hFFFF_FFFC, 32'h0000_0073, 1'b0, 0, 0);
    take_out("wrap", 0);

    // Asynchronous reset while in WAIT; responses during and at release are ignored.
    wait_req("rst", 32'h0000_0000);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    rsp_valid = 1'b1;
    rsp_data = 32'hBAD2_BAD2;
    @(negedge clk);
    check("rst_hold_noout", {31'd0, out_valid}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b0;
    check("rst_rel_noout", {31'd0, out_valid}, 32'd0);
    fetch("post", 32'h3000_0000, 32'h0000_0093, 1'b0, 0, 0);
    take_out("post", 0);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
